// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {A, Q, q-1} product register.
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH+3:0] prod,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+3:0] prod_next
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0]      acc;
  logic [AW-1:0]      m_ext;
  logic [2*WIDTH+3:0] sum;

  always_comb begin
    m_ext = {m[WIDTH], m};
    case (prod[1:0])
      2'b01:   acc = prod[2*WIDTH+3 -: AW] + m_ext;
      2'b10:   acc = prod[2*WIDTH+3 -: AW] - m_ext;
      default: acc = prod[2*WIDTH+3 -: AW];
    endcase
    sum       = {acc, prod[WIDTH+1:0]};
    prod_next = {sum[2*WIDTH+3], sum[2*WIDTH+3:1]};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential Booth multiplier / restoring divider with fixed WIDTH+2 cycle latency.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with err.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH + 4;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   m_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_nxt;
  logic             mul_signed;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic             cap_dz;
  logic             cap_err;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_booth_step (
    .prod     (prod_q),
    .m        (m_q),
    .prod_next(prod_nxt)
  );

`ifdef MULDIV_DIV_EN
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem_q, rem_nxt;
  logic [WIDTH-1:0] quo_q, quo_nxt;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH:0]   rem_sh, diff;
  logic             div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    div_signed = (op == OP_DIV);
    a_neg      = div_signed & a[WIDTH-1];
    b_neg      = div_signed & b[WIDTH-1];
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;
    // Remainder stays below the divisor, so the non-restored value fits WIDTH bits.
    rem_sh     = {rem_q, quo_q[WIDTH-1]};
    diff       = rem_sh - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end
`endif

  always_comb begin
    mul_signed = (op == OP_MULT);
    a_ext      = {mul_signed & a[WIDTH-1], a};
    b_ext      = {mul_signed & b[WIDTH-1], b};
    cap_dz     = 1'b0;
    cap_err    = 1'b0;
    res_hi     = prod_nxt[2*WIDTH:WIDTH+1];
    res_lo     = prod_nxt[WIDTH:1];
`ifdef MULDIV_DIV_EN
    cap_dz     = op[1] && (b == '0);
    // Final RUN cycle of a divide is the sign-fix cycle.
    if (op_q[1]) begin
      res_hi = neg_r_q ? -rem_q : rem_q;
      res_lo = neg_q_q ? -quo_q : quo_q;
    end
`else
    cap_err    = op[1];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      m_q      <= '0;
      prod_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      err      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DIV_EN
      op_q     <= OP_MULT;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH);
            m_q    <= a_ext;
            prod_q <= {{(WIDTH + 2){1'b0}}, b_ext, 1'b0};
`ifdef MULDIV_DIV_EN
            op_q    <= op;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
`endif
            if (cap_dz || cap_err) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= cap_dz;
              err      <= cap_err;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          prod_q <= prod_nxt;
`ifdef MULDIV_DIV_EN
          rem_q  <= rem_nxt;
          quo_q  <= quo_nxt;
`endif
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a queue scoreboard; covers both MULDIV_DIV_EN builds.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic         er;
    int           lat;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, div_zero, err;
  logic [W-1:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .err     (err),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one request from an IDLE cycle, waits (bounded) for done, then scores it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int lat, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic edz, input logic eer,
                        input int restart_at);
    exp_t e;
    int   n;
    bit   got;
    sb.push_back('{tag, eh, el, edz, eer, lat});
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      #1 start = (n == restart_at);
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({e.tag, "_busy"}, 64'(busy), 64'd1);
    chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    chk({e.tag, "_dz"}, 64'(div_zero), 64'(e.dz));
    chk({e.tag, "_err"}, 64'(err), 64'(e.er));
    @(posedge clk);
    #1;
    chk({e.tag, "_idle"}, 64'(busy), 64'd0);
    chk({e.tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h1, 0, 0, 0);
    run_op("mult_m1m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h0, 32'h1, 0, 0, 0);
`ifdef MULDIV_DIV_EN
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0, 0, 0);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 1, 32'd2, 32'd14, 1, 0, 0);
    run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 0, 0, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 0, 0, 0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 34, 32'h0, 32'hFFFFFFFF, 0, 0, 0);
`else
    run_op("div_noen", OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'h0, 32'h1, 0, 1, 0);
    run_op("multu_shift", OP_MULTU, 32'h12345678, 32'h10, 34, 32'h1, 32'h23456780, 0, 0, 0);
    run_op("divu_noen", OP_DIVU, 32'd100, 32'd7, 1, 32'h1, 32'h23456780, 0, 1, 0);
`endif

    // Second start in cycle 5 must be ignored: single done, unchanged latency.
    run_op("mult_restart", OP_MULT, 32'h7FFFFFFF, 32'h80000000, 34, 32'hC0000000, 32'h80000000,
           0, 0, 5);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("restart_extra_done", 64'(nd), 64'd0);

    run_op("mult_min_min", OP_MULT, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h0,
           0, 0, 0);
    run_op("multu_shift2", OP_MULTU, 32'h12345678, 32'h10, 34, 32'h1, 32'h23456780, 0, 0, 0);

    // Reset pulled low in cycle 10 of a MULT aborts without a done pulse.
    op    = OP_MULT;
    a     = 32'd5;
    b     = 32'd9;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
